// File: rtl/fetch_unit.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Keeps at most one request in flight to instruction memory and parks a
// returned word in a one-entry buffer when decode is stalled, so that stalls
// and redirects neither lose nor duplicate instructions.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        pc_write_enable_i,
  input  logic        ifid_write_enable_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instruction_o,
  output logic        fetch_stall_o
);

  logic [31:0] pc_q, pc_d;
  logic        outstanding_q, outstanding_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        squash_q, squash_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;

  logic resp;
  logic req;
  logic accept;

  // A response is usable only if it belongs to a live (non-squashed) request.
  assign resp = imem_rvalid_i && outstanding_q && !squash_q;

  // A new request may go out in the same cycle the previous response lands,
  // provided that response will be consumed (or dropped) this cycle. The
  // hold-buffer term guarantees the buffer can never be overwritten.
  assign req = rst_ni && pc_write_enable_i && !branch_taken_i && !hold_valid_q &&
               (!outstanding_q || (imem_rvalid_i && (squash_q || ifid_write_enable_i)));

  assign accept = req && imem_ready_i;

  assign imem_req_o       = req;
  assign imem_addr_o      = pc_q;
  assign if_valid_o       = if_valid_q;
  assign if_pc_o          = if_pc_q;
  assign if_instruction_o = if_instr_q;
  assign fetch_stall_o    = ifid_write_enable_i && !hold_valid_q && !resp && !branch_taken_i;

  // Next-state logic: request tracking, redirect handling and IF/ID source select.
  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    out_pc_d      = out_pc_q;
    squash_d      = squash_q;
    hold_valid_d  = hold_valid_q;
    hold_pc_d     = hold_pc_q;
    hold_instr_d  = hold_instr_q;
    if_valid_d    = if_valid_q;
    if_pc_d       = if_pc_q;
    if_instr_d    = if_instr_q;

    // Any response retires the in-flight request; stray rvalids are ignored.
    if (imem_rvalid_i && outstanding_q) begin
      outstanding_d = 1'b0;
      squash_d      = 1'b0;
    end

    if (accept) begin
      outstanding_d = 1'b1;
      out_pc_d      = pc_q;
      pc_d          = pc_q + 32'd4;
    end

    if (branch_taken_i) begin
      // Redirect flushes everything younger than the branch; an in-flight
      // request whose data has not yet arrived is marked for dropping.
      pc_d         = branch_target_i & ~32'h3;
      hold_valid_d = 1'b0;
      if_valid_d   = 1'b0;
      if_instr_d   = NOP_INSTR;
      if (outstanding_q && !imem_rvalid_i) begin
        squash_d = 1'b1;
      end
    end else if (ifid_write_enable_i) begin
      if (hold_valid_q) begin
        if_valid_d   = 1'b1;
        if_pc_d      = hold_pc_q;
        if_instr_d   = hold_instr_q;
        hold_valid_d = 1'b0;
      end else if (resp) begin
        if_valid_d = 1'b1;
        if_pc_d    = out_pc_q;
        if_instr_d = imem_rdata_i;
      end else begin
        if_valid_d = 1'b0;
        if_instr_d = NOP_INSTR;
      end
    end else if (resp) begin
      hold_valid_d = 1'b1;
      hold_pc_d    = out_pc_q;
      hold_instr_d = imem_rdata_i;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q          <= RESET_PC;
      outstanding_q <= 1'b0;
      out_pc_q      <= 32'h0;
      squash_q      <= 1'b0;
      hold_valid_q  <= 1'b0;
      hold_pc_q     <= 32'h0;
      hold_instr_q  <= NOP_INSTR;
      if_valid_q    <= 1'b0;
      if_pc_q       <= 32'h0;
      if_instr_q    <= NOP_INSTR;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      out_pc_q      <= out_pc_d;
      squash_q      <= squash_d;
      hold_valid_q  <= hold_valid_d;
      hold_pc_q     <= hold_pc_d;
      hold_instr_q  <= hold_instr_d;
      if_valid_q    <= if_valid_d;
      if_pc_q       <= if_pc_d;
      if_instr_q    <= if_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Instruction memory returns word(a) for
// address a after a programmable latency; expected values are hand-derived.
module tb_fetch_unit;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] MAGIC = 32'hC0DE_0000;

  logic        clk;
  logic        rst_n;
  logic        pc_we;
  logic        ifid_we;
  logic        bt;
  logic [31:0] tgt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instruction;
  logic        fetch_stall;

  int          n_vec;
  int          n_miss;

  // memory model state
  int          lat;
  int          cnt;
  logic        pend;
  logic [31:0] paddr;
  logic        inject;

  // combinational outputs sampled mid-cycle
  logic        c_req;
  logic [31:0] c_addr;
  logic        c_stall;

  fetch_unit dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .pc_write_enable_i   (pc_we),
    .ifid_write_enable_i (ifid_we),
    .branch_taken_i      (bt),
    .branch_target_i     (tgt),
    .imem_req_o          (imem_req),
    .imem_addr_o         (imem_addr),
    .imem_ready_i        (imem_ready),
    .imem_rvalid_i       (imem_rvalid),
    .imem_rdata_i        (imem_rdata),
    .if_valid_o          (if_valid),
    .if_pc_o             (if_pc),
    .if_instruction_o    (if_instruction),
    .fetch_stall_o       (fetch_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return MAGIC ^ a;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs at negedge, deliver memory data, sample
  // combinational outputs, record an accepted request, advance past posedge.
  task automatic step(input logic pwe, input logic iwe, input logic b, input logic [31:0] t);
    @(negedge clk);
    pc_we       = pwe;
    ifid_we     = iwe;
    bt          = b;
    tgt         = t;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    if (pend) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = word(paddr);
        pend        = 1'b0;
      end
    end
    if (inject) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      inject      = 1'b0;
    end
    #1;
    c_req   = imem_req;
    c_addr  = imem_addr;
    c_stall = fetch_stall;
    if (imem_req && imem_ready) begin
      pend  = 1'b1;
      cnt   = lat;
      paddr = imem_addr;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0; n_miss = 0;
    rst_n = 1'b0; pc_we = 1'b1; ifid_we = 1'b1; bt = 1'b0; tgt = 32'h0;
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    lat = 1; cnt = 0; pend = 1'b0; paddr = 32'h0; inject = 1'b0;
    c_req = 1'b0; c_addr = 32'h0; c_stall = 1'b0;

    // reset values
    step(1, 1, 0, 0);
    check_eq("rst_req",   c_req, 0);
    check_eq("rst_addr",  c_addr, 32'h0);
    check_eq("rst_valid", if_valid, 0);
    check_eq("rst_pc",    if_pc, 32'h0);
    check_eq("rst_instr", if_instruction, NOP);
    step(1, 1, 0, 0);
    rst_n = 1'b1;

    // 1: back-to-back fetch, one-cycle memory
    step(1, 1, 0, 0);
    check_eq("t1_req_a",   c_req, 1);
    check_eq("t1_addr_a",  c_addr, 32'h0);
    check_eq("t1_stall_a", c_stall, 1);
    check_eq("t1_valid_a", if_valid, 0);
    step(1, 1, 0, 0);
    check_eq("t1_addr_b",  c_addr, 32'h4);
    check_eq("t1_stall_b", c_stall, 0);
    check_eq("t1_valid_b", if_valid, 1);
    check_eq("t1_pc_b",    if_pc, 32'h0);
    check_eq("t1_ins_b",   if_instruction, word(32'h0));
    step(1, 1, 0, 0);
    check_eq("t1_addr_c",  c_addr, 32'h8);
    check_eq("t1_pc_c",    if_pc, 32'h4);
    step(1, 1, 0, 0);
    check_eq("t1_addr_d",  c_addr, 32'hC);
    check_eq("t1_pc_d",    if_pc, 32'h8);
    step(1, 1, 0, 0);
    check_eq("t1_addr_e",  c_addr, 32'h10);
    check_eq("t1_pc_e",    if_pc, 32'hC);

    // 2: decode stalled for 3 cycles while word@0x10 returns
    step(1, 0, 0, 0);
    check_eq("t2_req_f",   c_req, 0);
    check_eq("t2_stall_f", c_stall, 0);
    check_eq("t2_pc_f",    if_pc, 32'hC);
    step(1, 0, 0, 0);
    check_eq("t2_req_g",   c_req, 0);
    step(1, 0, 0, 0);
    check_eq("t2_req_h",   c_req, 0);
    check_eq("t2_pc_h",    if_pc, 32'hC);
    step(1, 1, 0, 0);
    check_eq("t2_req_i",   c_req, 0);
    check_eq("t2_stall_i", c_stall, 0);
    check_eq("t2_pc_i",    if_pc, 32'h10);
    check_eq("t2_ins_i",   if_instruction, word(32'h10));
    step(1, 1, 0, 0);
    check_eq("t2_req_j",   c_req, 1);
    check_eq("t2_addr_j",  c_addr, 32'h14);
    check_eq("t2_stall_j", c_stall, 1);
    check_eq("t2_valid_j", if_valid, 0);
    check_eq("t2_ins_j",   if_instruction, NOP);
    check_eq("t2_pc_j",    if_pc, 32'h10);
    step(1, 1, 0, 0);
    check_eq("t2_addr_k",  c_addr, 32'h18);
    check_eq("t2_pc_k",    if_pc, 32'h14);
    check_eq("t2_valid_k", if_valid, 1);
    step(1, 1, 0, 0);
    check_eq("t2_pc_l",    if_pc, 32'h18);
    lat = 2;
    step(1, 1, 0, 0);
    check_eq("t2_addr_m",  c_addr, 32'h20);
    check_eq("t2_pc_m",    if_pc, 32'h1C);

    // 3: redirect while 0x20 is in flight (data two cycles after accept)
    step(1, 1, 1, 32'h100);
    check_eq("t3_req_n",   c_req, 0);
    check_eq("t3_stall_n", c_stall, 0);
    check_eq("t3_valid_n", if_valid, 0);
    check_eq("t3_ins_n",   if_instruction, NOP);
    check_eq("t3_addr_n",  imem_addr, 32'h100);
    step(1, 1, 0, 0);
    check_eq("t3_req_o",   c_req, 1);
    check_eq("t3_addr_o",  c_addr, 32'h100);
    check_eq("t3_stall_o", c_stall, 1);
    check_eq("t3_valid_o", if_valid, 0);
    step(1, 1, 0, 0);
    check_eq("t3_req_p",   c_req, 0);
    check_eq("t3_valid_p", if_valid, 0);
    step(1, 1, 0, 0);
    check_eq("t3_addr_q",  c_addr, 32'h104);
    check_eq("t3_valid_q", if_valid, 1);
    check_eq("t3_pc_q",    if_pc, 32'h100);
    check_eq("t3_ins_q",   if_instruction, word(32'h100));

    // 4: redirect with hold buffer full and an rvalid in the same cycle
    step(1, 0, 0, 0);
    check_eq("t4_req_r",   c_req, 0);
    step(1, 0, 0, 0);
    check_eq("t4_req_s",   c_req, 0);
    check_eq("t4_pc_s",    if_pc, 32'h100);
    inject = 1'b1;
    step(1, 1, 1, 32'h100);
    check_eq("t4_req_t",   c_req, 0);
    check_eq("t4_valid_t", if_valid, 0);
    check_eq("t4_ins_t",   if_instruction, NOP);
    check_eq("t4_addr_t",  imem_addr, 32'h100);
    lat = 1;
    step(1, 1, 0, 0);
    check_eq("t4_req_u",   c_req, 1);
    check_eq("t4_addr_u",  c_addr, 32'h100);
    check_eq("t4_valid_u", if_valid, 0);
    step(1, 1, 0, 0);
    check_eq("t4_addr_v",  c_addr, 32'h104);
    check_eq("t4_pc_v",    if_pc, 32'h100);
    check_eq("t4_ins_v",   if_instruction, word(32'h100));

    // 5: address wrap and target alignment
    step(1, 1, 1, 32'hFFFF_FFFC);
    check_eq("t5_req_w",   c_req, 0);
    check_eq("t5_addr_w",  imem_addr, 32'hFFFF_FFFC);
    check_eq("t5_valid_w", if_valid, 0);
    step(1, 1, 0, 0);
    check_eq("t5_req_x",   c_req, 1);
    check_eq("t5_addr_x",  c_addr, 32'hFFFF_FFFC);
    check_eq("t5_wrap_x",  imem_addr, 32'h0);
    step(1, 1, 0, 0);
    check_eq("t5_addr_y",  c_addr, 32'h0);
    check_eq("t5_pc_y",    if_pc, 32'hFFFF_FFFC);
    check_eq("t5_ins_y",   if_instruction, word(32'hFFFF_FFFC));
    step(1, 1, 1, 32'h203);
    check_eq("t5_align_z", imem_addr, 32'h200);
    check_eq("t5_valid_z", if_valid, 0);
    step(1, 1, 0, 0);
    check_eq("t5_req_aa",  c_req, 1);
    check_eq("t5_addr_aa", c_addr, 32'h200);

    // 6: async reset with a request in flight; late rvalid must be ignored
    step(1, 0, 0, 0);
    check_eq("t6_req_ab",  c_req, 0);
    step(1, 1, 0, 0);
    check_eq("t6_pc_ac",   if_pc, 32'h200);
    check_eq("t6_ins_ac",  if_instruction, word(32'h200));
    lat = 3;
    step(1, 1, 0, 0);
    check_eq("t6_addr_ad", c_addr, 32'h204);
    step(1, 0, 0, 0);
    check_eq("t6_req_ae",  c_req, 0);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_req",   imem_req, 0);
    check_eq("t6_rst_addr",  imem_addr, 32'h0);
    check_eq("t6_rst_valid", if_valid, 0);
    check_eq("t6_rst_pc",    if_pc, 32'h0);
    check_eq("t6_rst_ins",   if_instruction, NOP);
    step(1, 1, 0, 0);
    check_eq("t6_rst_req2",  c_req, 0);
    rst_n = 1'b1;
    lat = 1;
    step(1, 1, 0, 0);
    check_eq("t6_req_af",   c_req, 1);
    check_eq("t6_addr_af",  c_addr, 32'h0);
    check_eq("t6_stall_af", c_stall, 1);
    check_eq("t6_valid_af", if_valid, 0);
    step(1, 1, 0, 0);
    check_eq("t6_addr_ag",  c_addr, 32'h4);
    check_eq("t6_valid_ag", if_valid, 1);
    check_eq("t6_pc_ag",    if_pc, 32'h0);
    check_eq("t6_ins_ag",   if_instruction, word(32'h0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
